fifo_uart_tx: RTL

Read-side consumer for the 8-entry byte FIFO. When the FIFO is non-empty, the block pops one byte through the FIFO's read port and serializes it on a UART line as 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. It lives entirely in the FIFO's read clock domain and connects directly to the FIFO's `read_en`, `mem_empty` and data-out signals.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_baud_counter.sv | 48 ++++
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// ============================================================================
// Module      : fifo_uart_pkg
// Description : Shared types and constants for the FIFO-fed UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;                 // start + 8 data + stop
  localparam int IDX_W      = $clog2(DATA_W);     // data bit index width

  // Transmitter sequencing: pop, wait for read data, then shift out a frame.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module      : uart_baud_counter
// Description : Free-running 0..CLKS_PER_BIT-1 counter that flags the last
//               cycle of each UART bit. Held at zero while clear_i is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  // Guard keeps the width legal even for an illegal parameter, so the
  // top-level check is the one that reports the problem.
  localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  // Terminal value always fits in CNT_W bits, so the compare is exact.
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == C_TERM);

  // Next count: wrap on terminal count, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module      : fifo_uart_tx
// Description : FIFO read-side consumer. Pops one byte whenever the FIFO is
//               non-empty and sends it as an 8N1 UART frame, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              mem_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              read_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be 2 or more");
  end
  if (FRAME_BITS != DATA_W + 2) begin : g_bad_frame_bits
    $error("fifo_uart_tx: FRAME_BITS must equal DATA_W + 2");
  end

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              tx_q,    tx_d;
  logic              read_en_q, read_en_d;
  logic              w_tick;
  logic              w_clear;

  // Bit timer only runs while a frame is on the line; it is therefore zero
  // on the edge that leaves LOAD, so START gets a full bit period.
  assign w_clear = !(state_q inside {ST_START, ST_DATA, ST_STOP});

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (read_clk),
    .rst_ni  (reset),
    .clear_i (w_clear),
    .tick_o  (w_tick)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (!mem_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Read data is valid one edge after the pop.
        shreg_d = fifo_data;
        idx_d   = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          // Index wraps 7 -> 0 after the last data bit.
          if (idx_q == '1) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx and read_en are decoded from next state so they come out of flops.
    read_en_d = (state_d == ST_FETCH);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // State, shift register and output flops.
  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      read_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      read_en_q <= read_en_d;
    end
  end

  assign tx      = tx_q;
  assign read_en = read_en_q;
  assign busy    = (state_q != ST_IDLE);
  assign tx_done = (state_q == ST_STOP) && w_tick;

endmodule

`default_nettype wire
